// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcode/funct constants, ALU operation encoding and the
//               decoded control bundle for the single-cycle MIPS subset core.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_LUI = 3'd7
    } alu_op_e;

    // Decoded control for one instruction; all-zero means "nop".
    typedef struct packed {
        alu_op_e alu_op;
        logic    zero_ext;    // immediate is zero-extended (andi/ori)
        logic    reg_dst;     // destination is rd rather than rt
        logic    alu_src;     // ALU B operand is the immediate
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_write;
        logic    branch;
        logic    branch_ne;   // branch on inequality (bne)
        logic    jump;
        logic    jal;         // write PC+4 to $31
        logic    jr;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mips_imem.sv
`default_nettype none
// ============================================================================
// Module      : mips_imem
// Description : Instruction memory. Read-only from the core; programs are
//               placed directly into the inner word array before reset ends.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_imem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   rdata_o
);

    // The core never writes instruction memory, so the write port is idle.
    mips_word_mem #(
        .WORDS (WORDS),
        .AW    (AW)
    ) mem (
        .clk     (clk),
        .we_i    (1'b0),
        .addr_i  (addr_i),
        .wdata_i (32'h0),
        .rdata_o (rdata_o)
    );

endmodule
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mips_regfile
// Description : 32x32 register file, two combinational read ports, one
//               write port. $0 is hard-wired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);

    logic [31:0] regs_q [0:31];

    // Clear every register on reset; ignore writes aimed at $0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? 32'h0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'h0 : regs_q[ra2_i];

endmodule
`default_nettype wire

// File: rtl/mips_word_mem.sv
`default_nettype none
// ============================================================================
// Module      : mips_word_mem
// Description : Generic 32-bit word memory, combinational read and
//               synchronous write. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_word_mem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [0:WORDS-1];

    // Word write on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule
`default_nettype wire

// File: rtl/mips_processor.sv
`default_nettype none
// ============================================================================
// Module      : mips_processor
// Description : Single-cycle 32-bit MIPS-subset CPU with internal
//               instruction memory, data memory and register file.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_processor
    import mips_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] dbg_pc,
    output logic [31:0] dbg_instr
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] pc_q, pc_d, pc_plus4, instr;
    logic [31:0] rs_data, rt_data, simm, imm_ext, alu_b, alu_res;
    logic [31:0] dmem_rdata, wb_data, br_target, jmp_target;
    logic [4:0]  wb_addr;
    logic        take_branch;
    ctrl_t       ctrl;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd, shamt;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];

    mips_imem #(.WORDS(IMEM_WORDS), .AW(IAW)) imem (
        .clk     (clk),
        .addr_i  (pc_q[IAW+1:2]),
        .rdata_o (instr)
    );

    // Decode opcode/funct into control; anything unrecognised stays a nop
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    FN_SLL:  ctrl.alu_op = ALU_SLL;
                    FN_SRL:  ctrl.alu_op = ALU_SRL;
                    FN_JR: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.jr        = 1'b1;
                    end
                    default: ctrl.reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_SLTI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT; end
            OP_ANDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.zero_ext = 1'b1; ctrl.alu_op = ALU_AND; end
            OP_ORI:  begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.zero_ext = 1'b1; ctrl.alu_op = ALU_OR; end
            OP_LUI:  begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_LUI; end
            OP_LW:   begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; end
            OP_SW:   begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; end
            OP_BEQ:  ctrl.branch = 1'b1;
            OP_BNE:  begin ctrl.branch = 1'b1; ctrl.branch_ne = 1'b1; end
            OP_J:    ctrl.jump = 1'b1;
            OP_JAL:  begin ctrl.jump = 1'b1; ctrl.jal = 1'b1; ctrl.reg_write = 1'b1; end
            default: ;
        endcase
    end

    mips_regfile rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1_i (rs),
        .ra2_i (rt),
        .we_i  (ctrl.reg_write),
        .wa_i  (wb_addr),
        .wd_i  (wb_data),
        .rd1_o (rs_data),
        .rd2_o (rt_data)
    );

    assign simm    = {{16{instr[15]}}, instr[15:0]};
    assign imm_ext = ctrl.zero_ext ? {16'h0, instr[15:0]} : simm;
    assign alu_b   = ctrl.alu_src ? imm_ext : rt_data;

    // ALU: wrapping arithmetic, shifts take the rt operand and shamt
    always_comb begin
        alu_res = 32'h0;
        case (ctrl.alu_op)
            ALU_ADD: alu_res = rs_data + alu_b;
            ALU_SUB: alu_res = rs_data - alu_b;
            ALU_AND: alu_res = rs_data & alu_b;
            ALU_OR:  alu_res = rs_data | alu_b;
            ALU_SLT: alu_res = {31'h0, ($signed(rs_data) < $signed(alu_b))};
            ALU_SLL: alu_res = rt_data << shamt;
            ALU_SRL: alu_res = rt_data >> shamt;
            ALU_LUI: alu_res = {instr[15:0], 16'h0};
            default: alu_res = 32'h0;
        endcase
    end

    // A store caught by reset must not land in memory
    mips_word_mem #(.WORDS(DMEM_WORDS), .AW(DAW)) dmem (
        .clk     (clk),
        .we_i    (ctrl.mem_write & rst_n),
        .addr_i  (alu_res[DAW+1:2]),
        .wdata_i (rt_data),
        .rdata_o (dmem_rdata)
    );

    assign pc_plus4    = pc_q + 32'd4;
    assign br_target   = pc_plus4 + {simm[29:0], 2'b00};
    assign jmp_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign take_branch = ctrl.branch & ((rs_data == rt_data) ^ ctrl.branch_ne);

    assign wb_addr = ctrl.jal ? 5'd31 : (ctrl.reg_dst ? rd : rt);
    assign wb_data = ctrl.jal ? pc_plus4 : (ctrl.mem_to_reg ? dmem_rdata : alu_res);

    // Next-PC selection: jr, then jumps, then taken branch, else PC+4
    always_comb begin
        pc_d = pc_plus4;
        if (ctrl.jr) begin
            pc_d = rs_data;
        end else if (ctrl.jump) begin
            pc_d = jmp_target;
        end else if (take_branch) begin
            pc_d = br_target;
        end
    end

    // Program counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign dbg_pc    = pc_q;
    assign dbg_instr = instr;

endmodule
`default_nettype wire

// File: tb/tb_mips_processor.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_processor
// Description : Scoreboard bench for mips_processor. An instruction-level
//               model predicts PC, instruction and register state per cycle;
//               a monitor compares them against the DUT on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_processor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dbg_pc, dbg_instr;

    mips_processor #(
        .IMEM_WORDS (256),
        .DMEM_WORDS (256),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dbg_pc    (dbg_pc),
        .dbg_instr (dbg_instr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [31:0][31:0] regs;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_imem [256];
    logic [31:0] m_dmem [256];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          running  = 1'b0;
    exp_t        mon_e;
    int          mon_bad;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.pc    = m_pc;
        e.instr = m_imem[m_pc[9:2]];
        for (int i = 0; i < 32; i++) e.regs[i] = m_regs[i];
        exp_q.push_back(e);
    endtask

    // Architectural interpreter: executes one instruction on the model state
    task automatic model_step();
        logic [31:0] ins, a, b, simm, zimm, pc4, npc, wd, addr;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, dst;
        bit          wr;
        ins  = m_imem[m_pc[9:2]];
        op   = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        rd   = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
        a    = m_regs[rs]; b = m_regs[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'h0, ins[15:0]};
        pc4  = m_pc + 32'd4;
        npc  = pc4; wr = 1'b0; dst = rt; wd = 32'h0;
        case (op)
            6'h00: begin
                dst = rd; wr = 1'b1;
                case (fn)
                    6'h20: wd = a + b;
                    6'h22: wd = a - b;
                    6'h24: wd = a & b;
                    6'h25: wd = a | b;
                    6'h2A: wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00: wd = b << sh;
                    6'h02: wd = b >> sh;
                    6'h08: begin wr = 1'b0; npc = a; end
                    default: wr = 1'b0;
                endcase
            end
            6'h08: begin wr = 1'b1; wd = a + simm; end
            6'h0A: begin wr = 1'b1; wd = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; end
            6'h0C: begin wr = 1'b1; wd = a & zimm; end
            6'h0D: begin wr = 1'b1; wd = a | zimm; end
            6'h0F: begin wr = 1'b1; wd = {ins[15:0], 16'h0}; end
            6'h23: begin addr = a + simm; wr = 1'b1; wd = m_dmem[addr[9:2]]; end
            6'h2B: begin addr = a + simm; m_dmem[addr[9:2]] = b; end
            6'h04: if (a == b) npc = pc4 + (simm << 2);
            6'h05: if (a != b) npc = pc4 + (simm << 2);
            6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
            6'h03: begin npc = {pc4[31:28], ins[25:0], 2'b00}; dst = 5'd31; wd = pc4; wr = 1'b1; end
            default: ;
        endcase
        if (wr && dst != 5'd0) m_regs[dst] = wd;
        m_pc = npc;
    endtask

    // Stimulus side: advance the model alongside the DUT and queue predictions
    always @(posedge clk) begin
        if (running && rst_n) begin
            model_step();
            push_exp();
        end
    end

    // Monitor: compare DUT state with the oldest prediction mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check32("pc", dbg_pc, mon_e.pc);
            check32("instr", dbg_instr, mon_e.instr);
            mon_bad = -1;
            for (int i = 0; i < 32; i++)
                if (mon_bad < 0 && dut.rf.regs_q[i] !== mon_e.regs[i]) mon_bad = i;
            n_checks++;
            if (mon_bad >= 0) begin
                n_errors++;
                $display("FAIL regs[%0d]: got %08h expected %08h", mon_bad,
                         dut.rf.regs_q[mon_bad], mon_e.regs[mon_bad]);
            end
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) begin
            m_imem[i] = 32'h0;
            dut.imem.mem.mem[i] = 32'h0;
        end
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        m_imem[idx] = w;
        dut.imem.mem.mem[idx] = w;
    endtask

    task automatic check_dmem();
        int bad = -1;
        for (int i = 0; i < 256; i++)
            if (bad < 0 && dut.dmem.mem[i] !== m_dmem[i]) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_errors++;
            $display("FAIL dmem[%0d]: got %08h expected %08h", bad, dut.dmem.mem[bad], m_dmem[bad]);
        end
    endtask

    // Expect the reset state, release reset and let n instructions execute
    task automatic release_and_run(input int n);
        model_reset();
        push_exp();
        @(negedge clk);
        #2;
        rst_n   = 1'b1;
        running = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic stop();
        running = 1'b0;
        rst_n   = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h27};
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        int          sel, off;
        rs  = 5'($urandom_range(0, 8));
        rt  = 5'($urandom_range(0, 8));
        rd  = 5'($urandom_range(0, 8));
        sh  = 5'($urandom_range(0, 31));
        imm = 16'($urandom_range(0, 65535));
        off = int'($urandom_range(0, 15)) - 8;
        sel = int'($urandom_range(0, 19));
        case (sel)
            0, 1, 2, 3, 4, 5, 6: return {6'h00, rs, rt, rd, sh, fns[$urandom_range(0, 7)]};
            7:  return {6'h00, 5'd31, 10'h0, 5'h0, 6'h08};
            8:  return {6'h08, rs, rt, imm};
            9:  return {6'h0A, rs, rt, imm};
            10: return {6'h0C, rs, rt, imm};
            11: return {6'h0D, rs, rt, imm};
            12: return {6'h0F, rs, rt, imm};
            13: return {6'h23, rs, rt, imm};
            14: return {6'h2B, rs, rt, imm};
            15: return {6'h04, rs, rt, off[15:0]};
            16: return {6'h05, rs, rt, off[15:0]};
            17: return {6'h02, 26'($urandom_range(0, 63))};
            18: return {6'h03, 26'($urandom_range(0, 63))};
            default: return {6'h3F, rs, rt, imm};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            m_dmem[i] = 32'h0;
            dut.dmem.mem[i] = 32'h0;
        end

        // Counting loop with a reset asserted in the middle of it
        clear_imem();
        put(0, 32'h20080000);
        put(1, 32'h21080001);
        put(2, 32'h1108FFFE);
        release_and_run(5);
        check32("loop t0 after 5", dut.rf.regs_q[8], 32'd2);
        check32("loop pc after 5", dbg_pc, 32'h4);
        stop();
        #1;
        check32("midreset pc", dbg_pc, 32'h0);
        check32("midreset t0", dut.rf.regs_q[8], 32'h0);
        check32("midreset instr", dbg_instr, 32'h20080000);
        release_and_run(6);
        check32("loop t0 after 6", dut.rf.regs_q[8], 32'd3);
        check32("loop pc after 6", dbg_pc, 32'h8);
        stop();

        // $0 protection and memory round trip
        clear_imem();
        put(0, 32'h20000005);   // addi $0,$0,5
        put(1, 32'h00004820);   // add  $t1,$0,$0
        put(2, 32'h20081234);   // addi $t0,$0,0x1234
        put(3, 32'hAC080008);   // sw   $t0,8($0)
        put(4, 32'h8C0B0008);   // lw   $t3,8($0)
        put(5, 32'h200AFFFF);   // addi $t2,$0,-1
        release_and_run(6);
        check32("zero reg", dut.rf.regs_q[0], 32'h0);
        check32("add from zero", dut.rf.regs_q[9], 32'h0);
        check32("lw roundtrip", dut.rf.regs_q[11], 32'h00001234);
        check32("addi minus one", dut.rf.regs_q[10], 32'hFFFFFFFF);
        check32("dmem word 2", dut.dmem.mem[2], 32'h00001234);
        check_dmem();
        stop();

        // Control flow and ALU edge cases
        clear_imem();
        put(0,  32'h20080007);  // addi $t0,$0,7
        put(1,  32'h2009FFFF);  // addi $t1,$0,-1
        put(2,  32'h200A0001);  // addi $t2,$0,1
        put(3,  32'h15080005);  // bne  $t0,$t0,+5 (not taken)
        put(4,  32'h08000010);  // j    0x40
        put(16, 32'h08000008);  // j    0x20
        put(8,  32'h0C000020);  // jal  0x80
        put(32, 32'h03E00008);  // jr   $31
        put(9,  32'h012A582A);  // slt  $t3,$t1,$t2
        put(10, 32'h3C0C7FFF);  // lui  $t4,0x7FFF
        put(11, 32'h358CFFFF);  // ori  $t4,$t4,0xFFFF
        put(12, 32'h018A6820);  // add  $t5,$t4,$t2
        put(13, 32'hFC000000);  // unsupported opcode
        release_and_run(13);
        check32("jal link", dut.rf.regs_q[31], 32'h00000024);
        check32("slt signed", dut.rf.regs_q[11], 32'd1);
        check32("lui ori", dut.rf.regs_q[12], 32'h7FFFFFFF);
        check32("add wrap", dut.rf.regs_q[13], 32'h80000000);
        check32("pc after nop op", dbg_pc, 32'h00000038);
        stop();

        // Random programs against the model
        for (int p = 0; p < 4; p++) begin
            clear_imem();
            for (int k = 0; k < 64; k++) put(k, rand_instr());
            release_and_run(150);
            check_dmem();
            stop();
        end

        repeat (2) @(negedge clk);
        check32("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_processor.md
Name:
mips_processor

Overview:
- Single-cycle 32-bit MIPS-subset processor: fetch, decode, execute, memory access and writeback all complete in one clock.
- Top-level CPU block; self-contained with internal instruction memory, data memory and register file.
- Programs are loaded by hierarchical write into the instruction memory array at time zero, before reset is released.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words.
- DMEM_WORDS, 256, data memory depth in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value while reset is asserted.

Ports:
- clk  input  1  Rising-edge clock; all state updates on posedge.
- rst_n  input  1  Asynchronous, active-low reset.
- dbg_pc  output  32  Current PC, for observation.
- dbg_instr  output  32  Instruction currently being executed.

Behaviour:
- Reset (rst_n=0, asynchronous): PC=RESET_PC and all 32 registers=0. dbg_pc=RESET_PC; dbg_instr=imem word at RESET_PC. Memories are not cleared by reset.
- Hierarchy is fixed: the instruction memory instance is named imem. It contains an instance named mem, which holds a word array named mem[0:IMEM_WORDS-1]. The bench writes imem.mem.mem[i] directly.
- Fetch: combinational read of imem.mem.mem[PC[log2(IMEM_WORDS)+1:2]]. Address wraps modulo depth. PC[1:0] is ignored.
- Unloaded imem words read as 0, which executes as a nop (sll $0).
- Register file: 32x32 with two combinational read ports and one write port on posedge. $0 always reads 0; writes to $0 are discarded.
- Data memory: combinational read, synchronous write on posedge. Word index is addr[log2(DMEM_WORDS)+1:2] and wraps.
- Supported instructions:
  - R-type (opcode 0): add, sub, and, or, slt (signed), sll, srl, jr. Results use wrapping 32-bit arithmetic; overflow produces no trap.
  - addi: sign-extended immediate, wrapping.
  - andi, ori: zero-extended immediate.
  - slti: signed compare.
  - lui.
  - lw, sw: address = rs + sext(imm).
  - beq, bne: taken target = PC+4 + (sext(imm)<<2).
  - j: target = {PC+4[31:28], target26, 2'b00}.
  - jal: $31 = PC+4, then jump as j.
- Next PC defaults to PC+4, wrapping at 2^32.
- Any unsupported opcode or funct executes as a nop: no register write, no memory write, PC+4.
- Each instruction's register write, memory write and PC update all commit on the same posedge. A read of a register written by the previous instruction sees the new value.
- Reset asserted mid-program: PC and registers clear immediately. The in-flight instruction does not commit.

Decomposition:
- Shared package mips_pkg: opcode constants, funct constants, ALU-op enum, and control-signal struct (reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch, branch_ne, jump, jal, jr).
- Sub-modules:
  - mips_imem: instance name imem, wrapping a generic word memory instance named mem with array mem.
  - mips_regfile: the register file.
- Control decode and the ALU are inline combinational logic in the top.

Test Plan:
- Counting loop. Load imem[0]=20080000 (addi $t0,$0,0), imem[1]=21080001 (addi $t0,$t0,1), imem[2]=1108FFFE (beq $t0,$t0,-2). Pulse rst_n low, then release. Required PC sequence is 0,4,8,4,8,… and $t0 reads 0,1,1,2,2,3 after successive posedges.
- Reset mid-run: assert rst_n low between edges during the loop. PC=0 and $t0=0 immediately; the loop restarts from 0.
- $0 protection: addi $0,$0,5 followed by add $t1,$0,$0 -> $t1=0.
- Memory round-trip: addi $t0,$0,0x1234; sw $t0,8($0); lw $t1,8($0) -> $t1=0x00001234. Also addi $t2,$0,-1 -> $t2=0xFFFFFFFF.
- bne not taken / j / jal: bne with equal operands -> PC+4. j 0x10 -> PC=0x40. jal from PC=0x20 -> $31=0x24. jr $31 returns PC=0x24.
- ALU edge: slt of 0xFFFFFFFF vs 1 -> 1. 0x7FFFFFFF+1 -> 0x80000000 with no trap. Unknown opcode 0x3F -> nop, PC+4.
